alu_operand_sequencer: RTL and testbench

- Upstream control/datapath stage for the 6-bit ALU in the McCoy core.
- Accepts 8-bit instruction bytes over a valid/ready handshake and decodes them.
- Holds a 4-entry register file, drives the ALU operands and function select, and writes the ALU result back into the register file.
- Exposes a registered output port for the OUT instruction.
- The ALU itself (op1 + op2 when aluFun=0, ~op1 when aluFun=1) is external and combinational; its result returns on alu_out in the same cycle.

---
 rtl/alu_operand_sequencer_if.sv | 24 ++
 rtl/alu_operand_sequencer.sv | 98 +++++++++
 tb/tb_alu_operand_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Handshake and ALU-side bus for the McCoy operand sequencer.
// master = upstream instruction source plus the external ALU; slave = sequencer.
interface alu_operand_sequencer_if #(parameter int DATA_W = 6);
  logic [7:0]        instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              alu_fun;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;

  modport master (
    output instr, instr_valid, alu_out,
    input  instr_ready, op1, op2, alu_fun, out_data, out_valid, busy
  );

  modport slave (
    input  instr, instr_valid, alu_out,
    output instr_ready, op1, op2, alu_fun, out_data, out_valid, busy
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Decodes instruction bytes, owns the 4-entry register file, feeds the
// external combinational ALU and writes its result back.
module alu_operand_sequencer #(
  parameter int DATA_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_operand_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_IMM, S_EXEC} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NOT = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  state_t                  r_state, w_state_nxt;
  logic [3:0][DATA_W-1:0]  r_rf;
  logic [1:0]              r_op_q, r_rd_q, r_rs_q;
  logic [DATA_W-1:0]       r_out_data;
  logic                    r_out_valid;

  logic                    w_ready, w_fire;
  logic [1:0]              w_opc, w_rd, w_rs;

  assign w_opc   = bus.instr[7:6];
  assign w_rd    = bus.instr[5:4];
  assign w_rs    = bus.instr[3:2];
  // Ready depends on state only, so no path from instr_valid to instr_ready.
  assign w_ready = (r_state != S_EXEC);
  assign w_fire  = bus.instr_valid && w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          case (w_opc)
            OP_ADD, OP_NOT: w_state_nxt = S_EXEC;
            OP_LDI:         w_state_nxt = S_IMM;
            default:        w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_IMM:   if (w_fire) w_state_nxt = S_IDLE;
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf        <= '0;
      r_op_q      <= '0;
      r_rd_q      <= '0;
      r_rs_q      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            case (w_opc)
              OP_ADD, OP_NOT: begin
                r_op_q <= w_opc;
                r_rd_q <= w_rd;
                r_rs_q <= w_rs;
              end
              OP_LDI: r_rd_q <= w_rd;
              default: begin
                r_out_data  <= r_rf[w_rs];
                r_out_valid <= 1'b1;
              end
            endcase
          end
        end
        S_IMM:   if (w_fire) r_rf[r_rd_q] <= bus.instr[DATA_W-1:0];
        // Writeback lands before IDLE, so the next instruction sees it.
        S_EXEC:  r_rf[r_rd_q] <= bus.alu_out;
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.op1         = r_rf[r_rd_q];
  assign bus.op2         = r_rf[r_rs_q];
  assign bus.alu_fun     = (r_state == S_EXEC) && r_op_q[0];
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: a byte-level reference model predicts every OUT value,
// direct probes cover EXEC operands, stalls, IMM hold and async reset.
module tb_alu_operand_sequencer;
  localparam int DATA_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.DATA_W(DATA_W)) bus ();
  alu_operand_sequencer #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // External ALU
  assign bus.alu_out = bus.alu_fun ? ~bus.op1 : DATA_W'(bus.op1 + bus.op2);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [DATA_W-1:0] m_rf [4];
  logic              m_pend;
  logic [1:0]        m_rd;
  logic [DATA_W-1:0] exp_q [$];
  int                outs_sent;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_pend = 1'b0;
    m_rd   = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pend) begin
      m_rf[m_rd] = b[DATA_W-1:0];
      m_pend = 1'b0;
    end else begin
      case (b[7:6])
        2'b00: m_rf[b[5:4]] = DATA_W'(m_rf[b[5:4]] + m_rf[b[3:2]]);
        2'b01: m_rf[b[5:4]] = ~m_rf[b[5:4]];
        2'b10: begin m_pend = 1'b1; m_rd = b[5:4]; end
        default: begin exp_q.push_back(m_rf[b[3:2]]); outs_sent++; end
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is consumed.
  task automatic send(input logic [7:0] b);
    int n;
    model_byte(b);
    bus.instr       = b;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // OUT monitor
  int strobes = 0, run = 0, max_run = 0;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      strobes++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) chk("spurious_out", 32'(bus.out_data), 32'hFFFF);
      else chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end else begin
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
    chk({tag, "_ovld"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_odata"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_afun"},  32'(bus.alu_fun), 32'd0);
  endtask

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    outs_sent = 0;
    model_reset();
    #12;
    chk_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // OUT R0..R3 back to back
    max_run = 0;
    send(8'hC0); send(8'hC4); send(8'hC8); send(8'hCC);
    @(negedge clk); @(negedge clk);
    chk("out_run4", 32'(max_run), 32'd4);

    // LDI / ADD / OUT
    send(8'h90); send(8'h05);
    send(8'hA0); send(8'h2A);
    send(8'h18);
    chk("exec_op1", 32'(bus.op1), 32'd5);
    chk("exec_op2", 32'(bus.op2), 32'd42);
    chk("exec_afun", 32'(bus.alu_fun), 32'd0);
    chk("exec_busy", 32'(bus.busy), 32'd1);
    send(8'hC4);

    // Wrap and NOT
    send(8'hB0); send(8'h3F);
    send(8'h3C);
    chk("dbl_op1", 32'(bus.op1), 32'h3F);
    chk("dbl_op2", 32'(bus.op2), 32'h3F);
    send(8'h70);
    chk("not_afun", 32'(bus.alu_fun), 32'd1);
    chk("not_op1", 32'(bus.op1), 32'h3E);
    send(8'hCC);

    // Valid held across an ADD: the OUT byte stalls exactly one cycle
    model_byte(8'h18);
    bus.instr = 8'h18; bus.instr_valid = 1'b1;
    @(negedge clk);
    model_byte(8'hC4);
    bus.instr = 8'hC4;
    chk("stall_ready0", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk("stall_ready1", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("stall_consumed", 32'(bus.busy), 32'd0);

    // IMM holds without valid
    send(8'h80);
    for (int i = 0; i < 5; i++) begin
      chk("imm_busy", 32'(bus.busy), 32'd1);
      chk("imm_ready", 32'(bus.instr_ready), 32'd1);
      @(negedge clk);
    end
    send(8'h11);
    send(8'hC0);
    @(negedge clk);

    // Reset mid-EXEC: the writeback is lost
    send(8'h00);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1; #1;
    chk_reset_state("rst_exec");
    model_reset();
    @(negedge clk); rst = 1'b0; @(negedge clk);
    send(8'hC0);

    // Reset mid-IMM: pending immediate is discarded
    send(8'h90); send(8'h05); send(8'h94);
    chk("pre_rst_imm", 32'(bus.busy), 32'd1);
    rst = 1'b1; #1;
    chk_reset_state("rst_imm");
    model_reset();
    @(negedge clk); rst = 1'b0; @(negedge clk);
    send(8'h05);   // decoded as ADD R0,R1, not as an immediate
    send(8'hC4); send(8'hC0);
    @(negedge clk); @(negedge clk); @(negedge clk);

    chk("q_drained", 32'(exp_q.size()), 32'd0);
    chk("strobe_cnt", 32'(strobes), 32'(outs_sent));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
